bcd_lap_stopwatch: RTL

//  Stopwatch core with parametrised minute width, BCD digit counters and a lap-capture ring buffer.

---
 rtl/bcd_lap_stopwatch_pkg.sv | 22 ++
 rtl/bcd_lap_stopwatch_digit_counter.sv | 36 +++
 rtl/bcd_lap_stopwatch.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/bcd_lap_stopwatch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : stopwatch_pkg
// Brief    : Shared state encoding, blank code and digit moduli for the
//            bcd_lap_stopwatch core.
// Revision : 1.0 - initial release
// ============================================================================
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_VIEW  = 2'd3
  } state_t;

  localparam logic [3:0] DEFAULT_BLANK_CODE = 4'd10;
  localparam int         CS_MOD             = 100;
  localparam int         SEC_MOD            = 60;

endpackage
`default_nettype wire

// File: rtl/bcd_lap_stopwatch_digit_counter.sv
`default_nettype none
// ============================================================================
// Module   : bcd_digit_counter
// Brief    : Single BCD digit, modulo MODULUS (<=10), with ripple carry out.
// Revision : 1.0 - initial release
// ============================================================================
module bcd_digit_counter #(
  parameter int MODULUS = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       inc,
  input  logic       clr,
  output logic [3:0] q,
  output logic       carry_out
);

  localparam logic [3:0] C_LAST = 4'(MODULUS - 1);

  logic [3:0] r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= 4'd0;
    end else if (clr) begin
      r_q <= 4'd0;
    end else if (inc) begin
      r_q <= (r_q == C_LAST) ? 4'd0 : r_q + 4'd1;
    end
  end

  assign q         = r_q;
  assign carry_out = inc & (r_q == C_LAST);

endmodule
`default_nettype wire

// File: rtl/bcd_lap_stopwatch.sv
`default_nettype none
// ============================================================================
// Module   : bcd_lap_stopwatch
// Brief    : M..M:SS:CC stopwatch with BCD digit chain, leading-zero blanking
//            and optional lap ring buffer (define STOPWATCH_LAP_EN).
// Revision : 1.0 - initial release
// ============================================================================
module bcd_lap_stopwatch
  import stopwatch_pkg::*;
#(
  parameter int         MIN_DIGITS = 2,
  parameter int         LAP_DEPTH  = 4,
  parameter logic [3:0] BLANK_CODE = DEFAULT_BLANK_CODE
) (
  input  logic                           mili_clk,
  input  logic                           reset,
  input  logic                           enable,
  input  logic                           tick,
  input  logic                           start_stop,
  input  logic                           lap,
  input  logic                           clear,
  input  logic                           lap_view,
  output logic [4*(MIN_DIGITS+4)-1:0]    digits,
  output logic                           running,
  output logic                           viewing,
  output logic [$clog2(LAP_DEPTH+1)-1:0] lap_count,
  output logic                           overflow
);

  localparam int C_NDIG  = MIN_DIGITS + 4;
  localparam int C_DW    = 4 * C_NDIG;
  localparam int C_CNT_W = $clog2(LAP_DEPTH + 1);
  localparam logic [C_DW-1:0] C_RESET_DIGITS = {{(C_NDIG-3){BLANK_CODE}}, 12'h000};

  state_t            r_state;
  logic              r_running;
  logic              r_viewing;
  logic              r_overflow;
  logic [C_DW-1:0]   r_digits;
  logic [C_DW-1:0]   w_live;
  logic [C_DW-1:0]   w_show;
  logic [C_DW-1:0]   w_disp;
  logic [C_NDIG:0]   w_carry;
  logic              w_clear;
  logic              w_ss;

  assign w_clear    = enable & clear;
  assign w_ss       = enable & start_stop & ~clear;
  assign w_carry[0] = tick & (r_state == ST_RUN);

  // Digit 0 is centisecond units; digit 3 (seconds tens) is the only base-6 digit.
  for (genvar i = 0; i < C_NDIG; i++) begin : g_digit
    localparam int C_MODV = (i == 3) ? SEC_MOD / 10 : (i < 2) ? CS_MOD / 10 : 10;
    bcd_digit_counter #(.MODULUS(C_MODV)) u_digit (
      .clk       (mili_clk),
      .rst_n     (reset),
      .inc       (w_carry[i]),
      .clr       (w_clear),
      .q         (w_live[4*i +: 4]),
      .carry_out (w_carry[i+1])
    );
  end

`ifdef STOPWATCH_LAP_EN
  localparam int C_PTR_W = (LAP_DEPTH > 1) ? $clog2(LAP_DEPTH) : 1;

  logic [C_DW-1:0]    r_lap_mem [LAP_DEPTH];
  logic [C_PTR_W-1:0] r_wr_ptr;
  logic [C_PTR_W-1:0] r_view_idx;
  logic [C_PTR_W-1:0] w_oldest;
  logic [C_CNT_W-1:0] r_lap_count;
  logic [C_CNT_W-1:0] r_view_step;
  logic               w_lap;
  logic               w_lv;

  function automatic logic [C_PTR_W-1:0] ptr_next(input logic [C_PTR_W-1:0] p);
    return (p == C_PTR_W'(LAP_DEPTH - 1)) ? '0 : p + C_PTR_W'(1);
  endfunction

  assign w_lap    = enable & lap & ~clear & ~start_stop & (r_state == ST_RUN);
  assign w_lv     = enable & lap_view & ~clear & ~start_stop;
  // Once the ring has wrapped, the write pointer sits on the oldest entry.
  assign w_oldest = (r_lap_count == C_CNT_W'(LAP_DEPTH)) ? r_wr_ptr : '0;

  always_ff @(posedge mili_clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr    <= '0;
      r_lap_count <= '0;
      for (int k = 0; k < LAP_DEPTH; k++) r_lap_mem[k] <= '0;
    end else if (w_clear) begin
      r_wr_ptr    <= '0;
      r_lap_count <= '0;
    end else if (w_lap) begin
      r_lap_mem[r_wr_ptr] <= w_live;
      r_wr_ptr            <= ptr_next(r_wr_ptr);
      if (r_lap_count != C_CNT_W'(LAP_DEPTH)) r_lap_count <= r_lap_count + C_CNT_W'(1);
    end
  end

  assign lap_count = r_lap_count;
  assign w_show    = r_viewing ? r_lap_mem[r_view_idx] : w_live;
`else
  logic w_unused_lap;
  assign w_unused_lap = lap ^ lap_view;
  assign lap_count    = '0;
  assign w_show       = w_live;
`endif

  always_ff @(posedge mili_clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_running  <= 1'b0;
      r_viewing  <= 1'b0;
      r_overflow <= 1'b0;
`ifdef STOPWATCH_LAP_EN
      r_view_idx  <= '0;
      r_view_step <= '0;
`endif
    end else begin
      if (w_clear) r_overflow <= 1'b0;
      else if (w_carry[C_NDIG]) r_overflow <= 1'b1;

      if (w_clear) begin
        r_state   <= ST_IDLE;
        r_running <= 1'b0;
        r_viewing <= 1'b0;
      end else if (w_ss) begin
        if (r_state == ST_RUN) begin
          r_state   <= ST_PAUSE;
          r_running <= 1'b0;
        end else begin
          r_state   <= ST_RUN;
          r_running <= 1'b1;
        end
        r_viewing <= 1'b0;
      end
`ifdef STOPWATCH_LAP_EN
      else if (w_lv && r_state == ST_PAUSE && r_lap_count != '0) begin
        r_state     <= ST_VIEW;
        r_viewing   <= 1'b1;
        r_view_idx  <= w_oldest;
        r_view_step <= '0;
      end else if (w_lv && r_state == ST_VIEW) begin
        if (r_view_step + C_CNT_W'(1) == r_lap_count) begin
          r_state   <= ST_PAUSE;
          r_viewing <= 1'b0;
        end else begin
          r_view_idx  <= ptr_next(r_view_idx);
          r_view_step <= r_view_step + C_CNT_W'(1);
        end
      end
`endif
    end
  end

  // Blank from the minute MSD down to seconds tens while every digit so far is zero.
  always_comb begin
    logic lead;
    lead   = 1'b1;
    w_disp = w_show;
    for (int i = C_NDIG - 1; i >= 3; i--) begin
      if (lead && w_show[4*i +: 4] == 4'd0) w_disp[4*i +: 4] = BLANK_CODE;
      else lead = 1'b0;
    end
  end

  always_ff @(posedge mili_clk or negedge reset) begin
    if (!reset) r_digits <= C_RESET_DIGITS;
    else        r_digits <= w_disp;
  end

  assign digits   = r_digits;
  assign running  = r_running;
  assign viewing  = r_viewing;
  assign overflow = r_overflow;

endmodule
`default_nettype wire
